tick_generator_mc: RTL and testbench
====================================

# tick_generator_mc

Multi-channel programmable tick generator: the parametrised successor to the single 8-bit clock divider in the MapleMojo fabric. Each of CHANNELS independent channels emits a one-cycle `tick` every `divider+1` clocks in periodic mode, or once per `start` trigger in one-shot mode. Each channel also provides a near-50% `phase` waveform for bit-cell timing on the Maple bus transmitter/receiver. Divider changes are glitch-free: a new value takes effect only at a period boundary or on restart.

## Interface
- `WIDTH`, default 8: counter/divider width per channel (≥2).
- `CHANNELS`, default 2: number of independent channels (≥1).

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `divider`  in  CHANNELS*WIDTH  channel n uses bits [n*WIDTH +: WIDTH]; period is value+1 clocks.
- `enable`  in  CHANNELS  periodic run request, level-sensitive.
- `oneshot`  in  CHANNELS  mode select, sampled on entry to RUN: 1 = one-shot, 0 = periodic.
- `start`  in  CHANNELS  one-cycle trigger/resync pulse.
- `tick`  out  CHANNELS  high for one cycle at terminal count.
- `busy`  out  CHANNELS  channel is in RUN.
- `phase`  out  CHANNELS  high during the second half of each period.

## Operation
Each channel holds the following registers:
- state IDLE/RUN
- `cnt` (WIDTH bits)
- `div_act` (WIDTH bits; the latched divider)
- `mode` (1 bit)

Reset values: IDLE, `cnt`=0, `div_act`=0, `mode`=0. All outputs are 0 after reset.

Decode:
- `busy` = (state==RUN).
- `tick` = RUN && `cnt`==`div_act`.
- `phase` = RUN && `cnt` ≥ ((`div_act`+1)>>1). Compute the sum in WIDTH+1 bits so `div_act`=all-ones does not overflow.

Transitions, evaluated per channel each edge in priority order:
1. `rst` → reset values.
2. `start`=1 → RUN, `cnt`←0, `div_act`←`divider`, `mode`←`oneshot`. Valid from IDLE or RUN; acts as retrigger/resync.
3. IDLE with `enable`=1 and `oneshot`=0 → RUN, `cnt`←0, `div_act`←`divider`, `mode`←0.
4. RUN, `mode`=0, `enable`=0 → IDLE, `cnt`←0.
5. RUN with `cnt`==`div_act`:
   - `mode`=1 → IDLE, `cnt`←0.
   - `mode`=0 → `cnt`←0 and `div_act`←`divider`. The divider is reloaded only at this wrap.
6. RUN otherwise → `cnt`←`cnt`+1.

Rules:
- `divider` changes mid-period have no effect until the next wrap or `start`.
- `enable` is ignored in one-shot mode.
- In IDLE with `oneshot`=1, only `start` launches the channel.
- `div_act`=0 in periodic mode: `tick` and `phase` stay high continuously.
- `div_act`=0 in one-shot mode: a single `tick` cycle.
- Channels share nothing except `clk`/`rst`.

## Timing
- Outputs are Moore-decoded from registers; there is no combinational path from inputs to outputs.
- Entry into RUN on edge E, with latched value D: `busy` rises in the cycle after E. `tick` is high in the cycle beginning at edge E+D, and again every D+1 cycles after that in periodic mode.
- One-shot: `busy` is high for exactly D+1 cycles. `tick` coincides with the last `busy` cycle.
- `enable` falling, sampled at edge F: `busy`, `tick` and `phase` are all 0 from edge F onward. There is no partial-period completion.
- Simultaneous events:
  - `start` together with terminal count: restart wins; no return to IDLE.
  - `start` together with `enable`=0 in periodic mode: `start` wins and the channel stays RUN for that edge. It drops on the next edge if `enable` is still 0.
- Reset mid-operation: all channels are IDLE on the next edge, with outputs 0 in the following cycle.

## Test plan
- CH0 periodic, `divider`=3, `enable` held high → `tick` every 4 cycles, first tick 3 cycles after `busy` rises; `phase` pattern 0,0,1,1 repeating.
- CH0 periodic at `divider`=3, change `divider` to 5 mid-period → current period stays 4 cycles; the following periods are 6 cycles with `phase` 0,0,0,1,1,1.
- CH1 one-shot, `divider`=2, single `start` pulse → `busy` high 3 cycles, one `tick` on the last of them, then IDLE; holding `enable` high causes no further ticks.
- One-shot retrigger: `start` asserted on the tick cycle with `divider`=4 → no IDLE gap; a new 5-cycle `busy` window follows.
- Edge values: `divider`=0 periodic → `tick`=1 every cycle. `divider`=8'hFF → period 256 cycles, `phase` high for cycles 128–255, no overflow.
- Periodic at `divider`=9, `rst` pulsed at `cnt`=5 → `busy`, `tick` and `phase` are 0 the next cycle. With `enable` still high after `rst` drops, the channel restarts cleanly with its first `tick` 9 cycles after `busy` rises. CH0 and CH1 are independent throughout.

Source files
------------

// File: rtl/tick_generator_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tick_generator_mc                                            |
// | Description : Multi-channel programmable tick generator. Each channel      |
// |               emits a one-cycle tick every divider+1 clocks (periodic) or  |
// |               once per start trigger (one-shot), plus a near-50% phase     |
// |               waveform for bit-cell timing. Divider updates only take      |
// |               effect at a period boundary or on restart.                   |
// | Parameters  : WIDTH    - counter/divider width per channel (>= 2)          |
// |               CHANNELS - number of independent channels (>= 1)            |
// | Ports       : clk      - clock                                             |
// |               rst      - synchronous active-high reset                     |
// |               divider  - per-channel divider, channel n at [n*WIDTH+:WIDTH]|
// |               enable   - per-channel periodic run request (level)          |
// |               oneshot  - per-channel mode select, 1 = one-shot             |
// |               start    - per-channel trigger / resync pulse                |
// |               tick     - one-cycle pulse at terminal count                 |
// |               busy     - channel is running                                |
// |               phase    - high during the second half of each period       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tick_generator_mc #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] divider,
   input  logic [CHANNELS-1:0]       enable,
   input  logic [CHANNELS-1:0]       oneshot,
   input  logic [CHANNELS-1:0]       start,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       busy,
   output logic [CHANNELS-1:0]       phase
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] C_CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH:0]   C_HALF_ONE = {{WIDTH{1'b0}}, 1'b1};

   for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch

      state_t           r_state;
      state_t           w_state_nxt;
      logic [WIDTH-1:0] r_cnt;
      logic [WIDTH-1:0] w_cnt_nxt;
      logic [WIDTH-1:0] r_div_act;
      logic [WIDTH-1:0] w_div_act_nxt;
      logic             r_mode;
      logic             w_mode_nxt;

      logic [WIDTH-1:0] w_div_in;
      logic             w_term;
      logic [WIDTH:0]   w_half;

      assign w_div_in = divider[ch*WIDTH +: WIDTH];
      assign w_term   = (r_cnt == r_div_act);

      // State register.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div_act <= '0;
            r_mode    <= 1'b0;
         end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div_act <= w_div_act_nxt;
            r_mode    <= w_mode_nxt;
         end
      end

      // Next-state logic. start has priority over everything so that it
      // acts as a retrigger even at terminal count or with enable low.
      always_comb begin
         w_state_nxt   = r_state;
         w_cnt_nxt     = r_cnt;
         w_div_act_nxt = r_div_act;
         w_mode_nxt    = r_mode;

         if (start[ch]) begin
            w_state_nxt   = ST_RUN;
            w_cnt_nxt     = '0;
            w_div_act_nxt = w_div_in;
            w_mode_nxt    = oneshot[ch];
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // One-shot channels are launched by start only.
                  if (enable[ch] && !oneshot[ch]) begin
                     w_state_nxt   = ST_RUN;
                     w_cnt_nxt     = '0;
                     w_div_act_nxt = w_div_in;
                     w_mode_nxt    = 1'b0;
                  end
               end
               ST_RUN: begin
                  if (!r_mode && !enable[ch]) begin
                     // Periodic stop is immediate; no partial-period finish.
                     w_state_nxt = ST_IDLE;
                     w_cnt_nxt   = '0;
                  end else if (w_term) begin
                     w_cnt_nxt = '0;
                     if (r_mode) begin
                        w_state_nxt = ST_IDLE;
                     end else begin
                        // The only point where a new divider is picked up
                        // while running, which keeps period changes glitch-free.
                        w_div_act_nxt = w_div_in;
                     end
                  end else begin
                     w_cnt_nxt = r_cnt + C_CNT_ONE;
                  end
               end
               default: begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = '0;
               end
            endcase
         end
      end

      // Midpoint computed one bit wider so an all-ones divider does not wrap.
      assign w_half = ({1'b0, r_div_act} + C_HALF_ONE) >> 1;

      assign busy[ch]  = (r_state == ST_RUN);
      assign tick[ch]  = (r_state == ST_RUN) && w_term;
      assign phase[ch] = (r_state == ST_RUN) && ({1'b0, r_cnt} >= w_half);

   end : g_ch

endmodule
`default_nettype wire

// File: tb/tb_tick_generator_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tick_generator_mc                                         |
// | Description : Self-checking bench for tick_generator_mc (2 x 8-bit).       |
// |               Expected per-cycle {tick,busy,phase} vectors are queued      |
// |               ahead of each scenario and popped as the DUT runs.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tick_generator_mc;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] divider;
   logic [1:0]  enable;
   logic [1:0]  oneshot;
   logic [1:0]  start;
   logic [1:0]  tick;
   logic [1:0]  busy;
   logic [1:0]  phase;

   int checks = 0;
   int errors = 0;

   // Packed as {tick[1:0], busy[1:0], phase[1:0]}.
   logic [5:0] q[$];

   tick_generator_mc #(
      .WIDTH    (8),
      .CHANNELS (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .divider (divider),
      .enable  (enable),
      .oneshot (oneshot),
      .start   (start),
      .tick    (tick),
      .busy    (busy),
      .phase   (phase)
   );

   always #5 clk = ~clk;

   // Expected {tick,busy,phase} for running cycle k with latched divider d.
   function automatic logic [2:0] per(int k, int d);
      int m;
      m = k % (d + 1);
      return {(m == d), 1'b1, (m >= (d + 1) / 2)};
   endfunction

   function automatic logic [5:0] pack2(logic [2:0] c0, logic [2:0] c1);
      return {c1[2], c0[2], c1[1], c0[1], c1[0], c0[0]};
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      rst     = 1'b1;
      divider = '0;
      enable  = '0;
      oneshot = '0;
      start   = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] exp;
      @(negedge clk);
      rst     = 1'b1;
      enable  = 2'b11;
      divider = 16'h0303;
      start   = 2'b11;
      for (int k = 0; k < 3; k++) q.push_back(6'b0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL reset k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 1) begin
            rst    = 1'b0;
            enable = 2'b00;
            start  = 2'b00;
         end
      end
   endtask

   task automatic test_periodic();
      logic [5:0] exp;
      apply_reset();
      divider[7:0] = 8'd3;
      enable[0]    = 1'b1;
      for (int k = 0; k < 13; k++)
         q.push_back(k < 12 ? pack2(per(k, 3), 3'b0) : 6'b0);
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL periodic_d3 k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 11) enable[0] = 1'b0;
      end
   endtask

   task automatic test_divider_change();
      logic [5:0] exp;
      apply_reset();
      divider[7:0] = 8'd3;
      enable[0]    = 1'b1;
      for (int k = 0; k < 17; k++) begin
         if (k < 4)       q.push_back(pack2(per(k, 3), 3'b0));
         else if (k < 16) q.push_back(pack2(per(k - 4, 5), 3'b0));
         else             q.push_back(6'b0);
      end
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL divider_change k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 1)  divider[7:0] = 8'd5;
         if (k == 15) enable[0]    = 1'b0;
      end
   endtask

   task automatic test_oneshot();
      logic [5:0] exp;
      apply_reset();
      divider[15:8] = 8'd2;
      oneshot[1]    = 1'b1;
      enable[1]     = 1'b1;
      start[1]      = 1'b1;
      for (int k = 0; k < 9; k++)
         q.push_back(k < 3 ? pack2(3'b0, {(k == 2), 1'b1, (k >= 1)}) : 6'b0);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL oneshot k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 0) start[1] = 1'b0;
      end
   endtask

   task automatic test_retrigger();
      logic [5:0] exp;
      apply_reset();
      divider[15:8] = 8'd4;
      oneshot[1]    = 1'b1;
      start[1]      = 1'b1;
      for (int k = 0; k < 13; k++) begin
         if (k < 5)       q.push_back(pack2(3'b0, {(k == 4), 1'b1, (k >= 2)}));
         else if (k < 10) q.push_back(pack2(3'b0, {(k == 9), 1'b1, (k >= 7)}));
         else             q.push_back(6'b0);
      end
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL retrigger k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 0) start[1] = 1'b0;
         if (k == 4) start[1] = 1'b1;
         if (k == 5) start[1] = 1'b0;
      end
   endtask

   task automatic test_start_periodic();
      logic [5:0] exp;
      apply_reset();
      divider[7:0] = 8'd3;
      start[0]     = 1'b1;
      for (int k = 0; k < 4; k++)
         q.push_back(k == 0 ? pack2(3'b010, 3'b0) : 6'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL start_no_enable k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 0) start[0] = 1'b0;
      end
   endtask

   task automatic test_edge_values();
      logic [5:0] exp;
      apply_reset();
      divider[7:0] = 8'd0;
      enable[0]    = 1'b1;
      for (int k = 0; k < 7; k++)
         q.push_back(k < 6 ? pack2(3'b111, 3'b0) : 6'b0);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL divider_zero k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 5) enable[0] = 1'b0;
      end

      apply_reset();
      divider[7:0] = 8'hFF;
      enable[0]    = 1'b1;
      for (int k = 0; k < 514; k++)
         q.push_back(k < 512 ? pack2(per(k, 255), 3'b0) : 6'b0);
      for (int k = 0; k < 514; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL divider_ff k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 511) enable[0] = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp;
      apply_reset();
      divider = {8'd2, 8'd9};
      enable  = 2'b11;
      for (int k = 0; k < 28; k++) begin
         if (k < 6)        q.push_back(pack2(per(k, 9), per(k, 2)));
         else if (k == 6)  q.push_back(6'b0);
         else if (k < 27)  q.push_back(pack2(per(k - 7, 9), per(k - 7, 2)));
         else              q.push_back(6'b0);
      end
      for (int k = 0; k < 28; k++) begin
         @(negedge clk);
         exp = q.pop_front();
         checks++;
         if ({tick, busy, phase} !== exp) begin
            errors++;
            $display("FAIL reset_mid k=%0d got %b expected %b", k, {tick, busy, phase}, exp);
         end
         if (k == 5)  rst    = 1'b1;
         if (k == 6)  rst    = 1'b0;
         if (k == 26) enable = 2'b00;
      end
   endtask

   initial begin
      rst     = 1'b1;
      divider = '0;
      enable  = '0;
      oneshot = '0;
      start   = '0;
      test_reset();
      test_periodic();
      test_divider_change();
      test_oneshot();
      test_retrigger();
      test_start_periodic();
      test_edge_values();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
